// File: rtl/poly_mult_sched_if.sv
// Control, position-RAM, dense-RAM and accumulate-command signals of the
// sparse x dense multiplier sequencer.
interface poly_mult_sched_if #(
    parameter int MAX_WEIGHT = 75,
    parameter int LOGW       = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LOG_WEIGHT = 7
);
    logic                  start_i;
    logic [MAX_WEIGHT-1:0] dummy_map_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    logic                  pos_rd_o;
    logic [LOG_WEIGHT-1:0] pos_addr_o;
    logic [LOGW-1:0]       pos_data_i;

    logic                  dense_rd_o;
    logic [ADDR_WIDTH-1:0] dense_addr_o;

    logic                  acc_en_o;
    logic                  acc_first_o;
    logic                  acc_dummy_o;
    logic [ADDR_WIDTH:0]   acc_tgt_o;
    logic [4:0]            acc_shift_o;

    modport master (
        input  start_i, dummy_map_i, pos_data_i,
        output busy_o, done_o, err_o,
               pos_rd_o, pos_addr_o,
               dense_rd_o, dense_addr_o,
               acc_en_o, acc_first_o, acc_dummy_o, acc_tgt_o, acc_shift_o
    );

    modport slave (
        output start_i, dummy_map_i, pos_data_i,
        input  busy_o, done_o, err_o,
               pos_rd_o, pos_addr_o,
               dense_rd_o, dense_addr_o,
               acc_en_o, acc_first_o, acc_dummy_o, acc_tgt_o, acc_shift_o
    );
endinterface

// File: rtl/poly_mult_sched.sv
// Constant-time slot sequencer: every slot, real or dummy, reads one position
// and sweeps the whole dense RAM, so run latency never depends on secret data.
module poly_mult_sched #(
    parameter int WEIGHT     = 66,
    parameter int MAX_WEIGHT = 75,
    parameter int LOGW       = 16,
    parameter int NWORDS     = 553,
    parameter int ADDR_WIDTH = 10,
    parameter int LOG_WEIGHT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    poly_mult_sched_if.master bus
);

    localparam int KW  = $clog2(MAX_WEIGHT + 1);
    localparam int RW  = $clog2(WEIGHT + 1);
    localparam int PCW = $clog2(MAX_WEIGHT + 1);
    localparam int TW  = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_POS_RD,
        S_POS_WAIT,
        S_SWEEP,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [MAX_WEIGHT-1:0] r_map;
    logic [KW-1:0]         r_k;
    logic [RW-1:0]         r_r;
    logic [ADDR_WIDTH-1:0] r_j;
    logic [LOGW-1:0]       r_pos;

    logic                  r_acc_en;
    logic                  r_acc_first;
    logic                  r_acc_dummy;
    logic [TW-1:0]         r_acc_tgt;
    logic [4:0]            r_acc_shift;

    logic [PCW-1:0]        w_popcnt;
    logic                  w_map_ok;
    logic                  w_last_word;
    logic                  w_last_slot;
    logic                  w_slot_dummy;
    logic [LOG_WEIGHT-1:0] w_pos_addr;

    // The map is only trusted if it marks exactly the expected number of dummies.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < MAX_WEIGHT; i++) begin
            w_popcnt = w_popcnt + PCW'(r_map[i]);
        end
    end

    assign w_map_ok     = (w_popcnt == PCW'(MAX_WEIGHT - WEIGHT));
    assign w_last_word  = (r_j == ADDR_WIDTH'(NWORDS - 1));
    assign w_last_slot  = (r_k == KW'(MAX_WEIGHT - 1));
    assign w_slot_dummy = r_map[r_k];
    // Trailing dummies re-read the last real entry so the address never runs off the RAM.
    assign w_pos_addr   = (r_r >= RW'(WEIGHT - 1)) ? LOG_WEIGHT'(WEIGHT - 1)
                                                   : LOG_WEIGHT'(r_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.busy_o       = 1'b0;
        bus.done_o       = 1'b0;
        bus.err_o        = 1'b0;
        bus.pos_rd_o     = 1'b0;
        bus.pos_addr_o   = '0;
        bus.dense_rd_o   = 1'b0;
        bus.dense_addr_o = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                bus.busy_o = 1'b1;
                if (w_map_ok) begin
                    w_next = S_POS_RD;
                end else begin
                    bus.err_o = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_POS_RD: begin
                bus.busy_o     = 1'b1;
                bus.pos_rd_o   = 1'b1;
                bus.pos_addr_o = w_pos_addr;
                w_next         = S_POS_WAIT;
            end
            S_POS_WAIT: begin
                bus.busy_o = 1'b1;
                w_next     = S_SWEEP;
            end
            S_SWEEP: begin
                bus.busy_o       = 1'b1;
                bus.dense_rd_o   = 1'b1;
                bus.dense_addr_o = r_j;
                if (w_last_word) begin
                    w_next = w_last_slot ? S_FLUSH : S_POS_RD;
                end
            end
            S_FLUSH: begin
                bus.busy_o = 1'b1;
                w_next     = S_DONE;
            end
            S_DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Slot/real counters advance on the last word so the next POS_RD sees the updated real index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map <= '0;
            r_k   <= '0;
            r_r   <= '0;
            r_j   <= '0;
            r_pos <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_map <= bus.dummy_map_i;
                        r_k   <= '0;
                        r_r   <= '0;
                    end
                end
                S_POS_WAIT: begin
                    r_pos <= bus.pos_data_i;
                    r_j   <= '0;
                end
                S_SWEEP: begin
                    r_j <= r_j + 1'b1;
                    if (w_last_word) begin
                        if (!w_slot_dummy) begin
                            r_r <= r_r + 1'b1;
                        end
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beats trail the dense read by one cycle to line up with the RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_en    <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc_dummy <= 1'b0;
            r_acc_tgt   <= '0;
            r_acc_shift <= '0;
        end else if (r_state == S_SWEEP) begin
            r_acc_en    <= 1'b1;
            r_acc_first <= (r_j == '0);
            r_acc_dummy <= w_slot_dummy;
            r_acc_tgt   <= TW'(r_j) + TW'(r_pos[LOGW-1:5]);
            r_acc_shift <= r_pos[4:0];
        end else begin
            r_acc_en    <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc_dummy <= 1'b0;
            r_acc_tgt   <= '0;
            r_acc_shift <= '0;
        end
    end

    assign bus.acc_en_o    = r_acc_en;
    assign bus.acc_first_o = r_acc_first;
    assign bus.acc_dummy_o = r_acc_dummy;
    assign bus.acc_tgt_o   = r_acc_tgt;
    assign bus.acc_shift_o = r_acc_shift;

endmodule

// File: tb/tb_poly_mult_sched.sv
// Self-checking bench for poly_mult_sched: random maps and positions checked
// against a slot-timeline reference model, plus directed boundary cases.
`timescale 1ns/1ps
module tb_poly_mult_sched;

    localparam int WEIGHT     = 5;
    localparam int MAX_WEIGHT = 8;
    localparam int LOGW       = 16;
    localparam int NWORDS     = 553;
    localparam int ADDR_WIDTH = 10;
    localparam int LOG_WEIGHT = 7;
    localparam int NDUMMY     = MAX_WEIGHT - WEIGHT;
    localparam int SLOT       = NWORDS + 2;
    localparam int RUN_LEN    = 3 + MAX_WEIGHT * SLOT;
    localparam int TIMEOUT    = RUN_LEN + 200;
    localparam int OUTW       = 14 + LOG_WEIGHT + 2 * ADDR_WIDTH;
    localparam int POS_MAX    = (2048 - NWORDS) * 32 - 1;

    typedef struct packed {
        int offset;
        int addr;
    } rd_t;

    typedef struct packed {
        int offset;
        int tgt;
        int shift;
        bit dummy;
        bit first;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    poly_mult_sched_if #(
        .MAX_WEIGHT(MAX_WEIGHT),
        .LOGW      (LOGW),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LOG_WEIGHT(LOG_WEIGHT)
    ) bus ();

    poly_mult_sched #(
        .WEIGHT    (WEIGHT),
        .MAX_WEIGHT(MAX_WEIGHT),
        .LOGW      (LOGW),
        .NWORDS    (NWORDS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LOG_WEIGHT(LOG_WEIGHT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    int tStart  = 0;
    bit logging = 1'b0;
    bit pendRd  = 1'b0;
    int pendAddr = 0;

    logic [LOGW-1:0] posRam [WEIGHT];

    beat_t obsBeats[$];
    beat_t expBeats[$];
    rd_t   obsPos[$];
    rd_t   expPos[$];
    rd_t   obsDense[$];
    rd_t   expDense[$];
    int    doneOffs[$];
    int    errOffs[$];
    int    busyOffs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Position RAM with one-cycle latency; outside the valid cycle the data bus carries garbage.
    always @(negedge clk) begin
        int off;
        off = cyc - tStart;
        if (pendRd && pendAddr < WEIGHT) bus.pos_data_i = posRam[pendAddr];
        else bus.pos_data_i = LOGW'($urandom);
        pendRd   = bus.pos_rd_o;
        pendAddr = int'(bus.pos_addr_o);
        if (logging) begin
            if (bus.busy_o)     busyOffs.push_back(off);
            if (bus.done_o)     doneOffs.push_back(off);
            if (bus.err_o)      errOffs.push_back(off);
            if (bus.pos_rd_o)   obsPos.push_back('{off, int'(bus.pos_addr_o)});
            if (bus.dense_rd_o) obsDense.push_back('{off, int'(bus.dense_addr_o)});
            if (bus.acc_en_o)
                obsBeats.push_back('{off, int'(bus.acc_tgt_o), int'(bus.acc_shift_o),
                                     bus.acc_dummy_o, bus.acc_first_o});
        end
    end

    function automatic logic [OUTW-1:0] allOutputs();
        return {bus.busy_o, bus.done_o, bus.err_o, bus.pos_rd_o, bus.pos_addr_o,
                bus.dense_rd_o, bus.dense_addr_o, bus.acc_en_o, bus.acc_first_o,
                bus.acc_dummy_o, bus.acc_tgt_o, bus.acc_shift_o};
    endfunction

    function automatic int busyAt(input int off);
        int hit = 0;
        foreach (busyOffs[i]) if (busyOffs[i] == off) hit = 1;
        return hit;
    endfunction

    function automatic logic [MAX_WEIGHT-1:0] randMap(input int ones);
        logic [MAX_WEIGHT-1:0] m = '0;
        while ($countones(m) < ones) m[$urandom_range(MAX_WEIGHT - 1, 0)] = 1'b1;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic checkIdleOutputs(input string tag);
        nChecks++;
        assert (allOutputs() === '0) nPass++;
        else $error("[TB] FAIL %s: observed outputs %h expected 0", tag, allOutputs());
    endtask

    // Reference timeline: slot k starts 2+k*SLOT cycles after the start edge.
    task automatic buildExpected(input logic [MAX_WEIGHT-1:0] map);
        int nReal = 0;
        expBeats.delete();
        expPos.delete();
        expDense.delete();
        for (int k = 0; k < MAX_WEIGHT; k++) begin
            int base = 2 + k * SLOT;
            int addr = (nReal < WEIGHT - 1) ? nReal : WEIGHT - 1;
            int pos  = int'(posRam[addr]);
            expPos.push_back('{base, addr});
            for (int j = 0; j < NWORDS; j++) begin
                expDense.push_back('{base + 2 + j, j});
                expBeats.push_back('{base + 3 + j, j + pos / 32, pos % 32, map[k], j == 0});
            end
            if (!map[k]) nReal++;
        end
    endtask

    task automatic startRun(input logic [MAX_WEIGHT-1:0] map, input bit hold);
        @(negedge clk); #1;
        obsBeats.delete();
        obsPos.delete();
        obsDense.delete();
        doneOffs.delete();
        errOffs.delete();
        busyOffs.delete();
        tStart          = cyc;
        logging         = 1'b1;
        bus.dummy_map_i = map;
        bus.start_i     = 1'b1;
        @(negedge clk); #1;
        if (!hold) bus.start_i = 1'b0;
    endtask

    task automatic waitRunEnd();
        int waited = 0;
        while (doneOffs.size() == 0 && errOffs.size() == 0 && waited < TIMEOUT) begin
            @(negedge clk); #1;
            waited++;
        end
        checkOutput("run terminates", int'(doneOffs.size() + errOffs.size() > 0), 1);
        repeat (2) begin
            @(negedge clk); #1;
        end
        logging     = 1'b0;
        bus.start_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic [MAX_WEIGHT-1:0] map, input bit hold);
        startRun(map, hold);
        waitRunEnd();
    endtask

    task automatic compareLists(input string tag);
        int fails;
        checkOutput({tag, " pos read count"}, obsPos.size(), expPos.size());
        fails = 0;
        for (int i = 0; i < obsPos.size() && i < expPos.size() && fails < 4; i++) begin
            nChecks++;
            assert (obsPos[i] === expPos[i]) nPass++;
            else begin
                fails++;
                $error("[TB] FAIL %s pos[%0d]: observed cyc %0d addr %0d expected cyc %0d addr %0d",
                       tag, i, obsPos[i].offset, obsPos[i].addr, expPos[i].offset, expPos[i].addr);
            end
        end
        checkOutput({tag, " dense read count"}, obsDense.size(), expDense.size());
        fails = 0;
        for (int i = 0; i < obsDense.size() && i < expDense.size() && fails < 4; i++) begin
            nChecks++;
            assert (obsDense[i] === expDense[i]) nPass++;
            else begin
                fails++;
                $error("[TB] FAIL %s dense[%0d]: observed cyc %0d addr %0d expected cyc %0d addr %0d",
                       tag, i, obsDense[i].offset, obsDense[i].addr,
                       expDense[i].offset, expDense[i].addr);
            end
        end
        checkOutput({tag, " beat count"}, obsBeats.size(), expBeats.size());
        fails = 0;
        for (int i = 0; i < obsBeats.size() && i < expBeats.size() && fails < 4; i++) begin
            nChecks++;
            assert (obsBeats[i] === expBeats[i]) nPass++;
            else begin
                fails++;
                $error("[TB] FAIL %s beat[%0d]: observed cyc %0d tgt %0d sh %0d dum %0d first %0d expected cyc %0d tgt %0d sh %0d dum %0d first %0d",
                       tag, i, obsBeats[i].offset, obsBeats[i].tgt, obsBeats[i].shift,
                       obsBeats[i].dummy, obsBeats[i].first, expBeats[i].offset,
                       expBeats[i].tgt, expBeats[i].shift, expBeats[i].dummy, expBeats[i].first);
            end
        end
    endtask

    task automatic checkRun(input string tag);
        int busyIn = 0;
        checkOutput({tag, " done count"}, doneOffs.size(), 1);
        if (doneOffs.size() > 0) checkOutput({tag, " done cycle"}, doneOffs[0], RUN_LEN);
        checkOutput({tag, " err count"}, errOffs.size(), 0);
        foreach (busyOffs[i]) if (busyOffs[i] >= 1 && busyOffs[i] <= RUN_LEN) busyIn++;
        checkOutput({tag, " busy cycles"}, busyIn, RUN_LEN);
        checkOutput({tag, " busy after done"}, busyAt(RUN_LEN + 1), 0);
        compareLists(tag);
    endtask

    task automatic checkReject(input string tag);
        checkOutput({tag, " err count"}, errOffs.size(), 1);
        if (errOffs.size() > 0) checkOutput({tag, " err cycle"}, errOffs[0], 1);
        checkOutput({tag, " busy cycles"}, busyOffs.size(), 1);
        checkOutput({tag, " busy at check"}, busyAt(1), 1);
        checkOutput({tag, " busy after err"}, busyAt(2), 0);
        checkOutput({tag, " done count"}, doneOffs.size(), 0);
        checkOutput({tag, " pos reads"}, obsPos.size(), 0);
        checkOutput({tag, " dense reads"}, obsDense.size(), 0);
        checkOutput({tag, " beats"}, obsBeats.size(), 0);
    endtask

    initial begin
        logic [MAX_WEIGHT-1:0] map;
        int cnt;

        bus.start_i     = 1'b0;
        bus.dummy_map_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("reset state");
        rst_n = 1'b1;
        @(negedge clk); #1;
        checkIdleOutputs("idle after release");

        // Leading dummies, positions 100+i.
        $display("[TB] leading-dummy run");
        for (int i = 0; i < WEIGHT; i++) posRam[i] = LOGW'(100 + i);
        map = '0;
        for (int i = 0; i < NDUMMY; i++) map[i] = 1'b1;
        buildExpected(map);
        applyStimulus(map, 1'b0);
        checkRun("lead");
        cnt = 0;
        for (int i = 0; i < NDUMMY * NWORDS && i < obsBeats.size(); i++) cnt += int'(obsBeats[i].dummy);
        checkOutput("lead leading dummy beats", cnt, NDUMMY * NWORDS);
        if (obsBeats.size() > NDUMMY * NWORDS) begin
            checkOutput("lead first real tgt", obsBeats[NDUMMY * NWORDS].tgt, 3);
            checkOutput("lead first real shift", obsBeats[NDUMMY * NWORDS].shift, 4);
            checkOutput("lead first real first", int'(obsBeats[NDUMMY * NWORDS].first), 1);
        end

        // Trailing dummies, random positions.
        $display("[TB] trailing-dummy run");
        for (int i = 0; i < WEIGHT; i++) posRam[i] = LOGW'($urandom_range(POS_MAX, 0));
        map = '0;
        for (int i = WEIGHT; i < MAX_WEIGHT; i++) map[i] = 1'b1;
        buildExpected(map);
        applyStimulus(map, 1'b0);
        checkRun("trail");
        for (int k = WEIGHT; k < MAX_WEIGHT && k < obsPos.size(); k++)
            checkOutput("trail dummy pos addr", obsPos[k].addr, WEIGHT - 1);
        cnt = 0;
        foreach (obsBeats[i]) if (i >= WEIGHT * NWORDS) cnt += int'(obsBeats[i].dummy);
        checkOutput("trail trailing dummy beats", cnt, NDUMMY * NWORDS);

        // Random map, maximum-offset position in entry 0.
        $display("[TB] random map with large position");
        for (int i = 0; i < WEIGHT; i++) posRam[i] = LOGW'($urandom_range(POS_MAX, 0));
        posRam[0] = 16'h1FFF;
        map = randMap(NDUMMY);
        buildExpected(map);
        applyStimulus(map, 1'b0);
        checkRun("rand");
        if (obsBeats.size() > NWORDS - 1) begin
            checkOutput("rand j552 tgt", obsBeats[NWORDS - 1].tgt, 807);
            checkOutput("rand j552 shift", obsBeats[NWORDS - 1].shift, 31);
        end

        // Rejected maps: one dummy too few and one too many.
        $display("[TB] rejected maps");
        applyStimulus(randMap(NDUMMY - 1), 1'b0);
        checkReject("reject low");
        applyStimulus(randMap(NDUMMY + 1), 1'b0);
        checkReject("reject high");

        // Start held high: exactly one run, next one begins right after done.
        $display("[TB] held start");
        for (int i = 0; i < WEIGHT; i++) posRam[i] = LOGW'($urandom_range(POS_MAX, 0));
        map = randMap(NDUMMY);
        buildExpected(map);
        applyStimulus(map, 1'b1);
        checkRun("hold");
        checkOutput("hold restart busy", busyAt(RUN_LEN + 2), 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Asynchronous reset in the middle of slot 5's sweep.
        $display("[TB] reset mid-sweep");
        map = randMap(NDUMMY);
        startRun(map, 1'b0);
        repeat (5 * SLOT + 201) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("async reset outputs");
        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs("held reset outputs");
        checkOutput("reset done count", doneOffs.size(), 0);
        checkOutput("reset err count", errOffs.size(), 0);
        logging = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < WEIGHT; i++) posRam[i] = LOGW'($urandom_range(POS_MAX, 0));
        map = randMap(NDUMMY);
        buildExpected(map);
        applyStimulus(map, 1'b0);
        checkRun("post reset");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/poly_mult_sched.md
# poly_mult_sched

Constant-time sequencer for the sparse × dense polynomial multiplier. It walks MAX_WEIGHT slots, where WEIGHT slots are real and the rest are dummy, following a dummy map latched at start. For every slot it reads one position from the position RAM, then sweeps every word of the dense random-bits RAM, emitting per-word accumulate commands (target word offset, bit shift, dummy flag) to the accumulator datapath. Slot timing is identical for real and dummy slots, so total latency is independent of the map and of the position values.

## Interface
Parameters:
- WEIGHT, 66: number of real sparse positions (position RAM depth).
- MAX_WEIGHT, 75: total slots per run (real + dummy).
- LOGW, 16: position width in bits.
- NWORDS, 553: dense RAM words of 32 bits swept per slot.
- ADDR_WIDTH, 10: dense RAM address width.
- LOG_WEIGHT, 7: position RAM address width.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start_i, in, 1: start request; sampled only in IDLE.
- dummy_map_i, in, MAX_WEIGHT: bit k = 1 means slot k is dummy; latched on accepted start.
- busy_o, out, 1: high from the cycle after start is accepted until DONE inclusive.
- done_o, out, 1: one-cycle pulse at run completion.
- err_o, out, 1: one-cycle pulse when the map is rejected.
- pos_rd_o, out, 1: position RAM read strobe.
- pos_addr_o, out, LOG_WEIGHT: position RAM address.
- pos_data_i, in, LOGW: position RAM read data, valid the cycle after pos_rd_o.
- dense_rd_o, out, 1: dense RAM read strobe.
- dense_addr_o, out, ADDR_WIDTH: dense RAM address.
- acc_en_o, out, 1: accumulate beat; dense RAM data is valid in the same cycle.
- acc_first_o, out, 1: first beat of a slot.
- acc_dummy_o, out, 1: beat belongs to a dummy slot; the datapath routes it to the dummy accumulator.
- acc_tgt_o, out, ADDR_WIDTH+1: target word = j + pos[LOGW-1:5], zero-extended. No modular reduction.
- acc_shift_o, out, 5: pos[4:0].

## Operation
- FSM states: IDLE, CHECK, POS_RD, POS_WAIT, SWEEP, FLUSH, DONE.
- IDLE: all outputs 0. When start_i = 1, latch dummy_map_i, clear slot counter k and real counter r, then go to CHECK.
- CHECK (1 cycle): compute the popcount of the latched map.
  - If popcount ≠ MAX_WEIGHT−WEIGHT: pulse err_o, go to IDLE; no RAM access occurs.
  - Otherwise go to POS_RD.
- POS_RD: pos_rd_o = 1, pos_addr_o = min(r, WEIGHT−1). Dummy slots also issue a read, so RAM activity is uniform. Go to POS_WAIT.
- POS_WAIT: capture pos_data_i into pos_q. Go to SWEEP with j = 0.
- SWEEP (NWORDS cycles): dense_rd_o = 1, dense_addr_o = j; j increments each cycle.
  - Accumulate outputs are registered one cycle behind the read. In the following cycle: acc_en_o = 1, acc_tgt_o = j_prev + pos_q[LOGW-1:5], acc_shift_o = pos_q[4:0], acc_dummy_o = map[k], acc_first_o = (j_prev == 0).
  - When j = NWORDS−1:
    - If map[k] = 0, increment r.
    - Increment k.
    - If k = MAX_WEIGHT−1, go to FLUSH; otherwise go to POS_RD.
- The last accumulate beat of a slot overlaps the next slot's POS_RD cycle. This is legal because the two use different resources.
- FLUSH: emits the final accumulate beat, then goes to DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- At run end, r equals WEIGHT.
- rst_n low at any time, including mid-sweep: all state and outputs clear to 0 asynchronously, with no done_o or err_o pulse. On release the block is in IDLE.

## Timing
- Reset value of every output is 0.
- Start sampled at edge T:
  - CHECK occupies cycle T+1.
  - Slot k's POS_RD occurs at cycle T+2+k·(NWORDS+2).
- Slot length is NWORDS+2 cycles for every slot, real or dummy.
- Dense RAM read latency is 1 cycle. Position RAM read latency is 1 cycle.
- FLUSH occurs at T+2+MAX_WEIGHT·(NWORDS+2).
- done_o pulses at T+3+MAX_WEIGHT·(NWORDS+2), which is T+41628 at defaults.
- busy_o is high for cycles T+1 through the done_o cycle.
- On map rejection: err_o pulses at T+1, and busy_o is high only in T+1.
- A new start is accepted at the earliest in the cycle after the done_o or err_o pulse.

## Test plan
- Default params, dummy map = bits 0..8 set, position RAM holds 100+i at entry i:
  - done_o at start+41628.
  - Exactly 75·553 acc_en_o beats; the first 9·553 beats have acc_dummy_o = 1.
  - Slot 9 first beat: acc_tgt_o = 3, acc_shift_o = 4 (position 100).
- Dummy map = bits 66..74 set: the same done_o cycle as the previous scenario; the final 9 slots read pos_addr_o = 65 and have acc_dummy_o = 1.
- Map with popcount 8 or 10: err_o pulses at start+1, busy_o falls at start+2, and zero pos_rd_o/dense_rd_o strobes occur.
- Position 0x1FFF (0x1FFF>>5 = 255) at j = 552: acc_tgt_o = 807, acc_shift_o = 31, with no truncation.
- start_i held high throughout a run: only one run occurs; the next run begins in the cycle after done_o.
- rst_n pulsed low in slot 40 mid-sweep: all outputs become 0 immediately with no done_o pulse; after release a fresh start completes with nominal timing.
